// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART word serializer.
// Holds the frame FSM state encoding, the default preamble byte and byte-order selection.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        SEND,
        FIN
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    // Maps the running byte counter onto the byte lane of the captured word.
    function automatic int byte_index(input int cnt, input int nbytes, input bit lsb_first);
        return lsb_first ? cnt : (nbytes - 1 - cnt);
    endfunction

endpackage

// File: rtl/uart_word_serializer_if.sv
// Handshake bundle between the result source, the serializer and the UART TX FIFO write port.
// The serializer uses the slave view; the driving side (core logic or bench) uses the master view.
interface uart_word_serializer_if #(
    parameter int DATA_W = 64
);
    logic              start;
    logic [DATA_W-1:0] data_in;
    logic              tx_full;
    logic [7:0]        data_out;
    logic              wr;
    logic              rd;
    logic              busy;
    logic              frame_done;

    modport master (
        output start, data_in, tx_full,
        input  data_out, wr, rd, busy, frame_done
    );

    modport slave (
        input  start, data_in, tx_full,
        output data_out, wr, rd, busy, frame_done
    );
endinterface

// File: rtl/uart_word_serializer_rise.sv
// Rising-edge detector: registers the input level and flags a low-to-high transition.
// Edge output is combinational from the live input; the history register clears on reset.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_rise
);
    logic r_sig_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sig_d <= 1'b0;
        end else begin
            r_sig_d <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_sig_d;

endmodule

// File: rtl/uart_word_serializer.sv
// Captures a DATA_W-bit word on a start edge and writes it byte by byte into the UART TX FIFO.
// Optional sync preamble and selectable byte order; tx_full stalls writes without losing bytes.
module uart_word_serializer
    import uart_pkg::*;
#(
    parameter int         DATA_W    = 64,
    parameter int         LSB_FIRST = 1,
    parameter int         SYNC_EN   = 0,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_word_serializer_if.slave bus
);
    localparam int NBYTES = DATA_W / 8;
    localparam int CNT_W  = $clog2(NBYTES + 2);

    state_t            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_shadow, w_shadow_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [7:0]        r_data_out, w_data_out_nxt;
    logic              r_wr, w_wr_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic              w_rise;
    int                w_idx;
    logic [7:0]        w_sel;

    rise_detect u_rise (
        .clk    (clk),
        .rst    (rst),
        .i_sig  (bus.start),
        .o_rise (w_rise)
    );

    always_comb begin
        w_idx = byte_index(int'(r_cnt), NBYTES, LSB_FIRST != 0);
        w_sel = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (i == w_idx) begin
                w_sel = r_shadow[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_shadow   <= '0;
            r_cnt      <= '0;
            r_data_out <= '0;
            r_wr       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shadow   <= w_shadow_nxt;
            r_cnt      <= w_cnt_nxt;
            r_data_out <= w_data_out_nxt;
            r_wr       <= w_wr_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Edges arriving outside IDLE fall through the case untouched, so they are dropped.
    always_comb begin
        w_state_nxt    = r_state;
        w_shadow_nxt   = r_shadow;
        w_cnt_nxt      = r_cnt;
        w_data_out_nxt = r_data_out;
        w_wr_nxt       = 1'b0;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_shadow_nxt = bus.data_in;
                    w_cnt_nxt    = '0;
                    w_busy_nxt   = 1'b1;
                    w_state_nxt  = (SYNC_EN != 0) ? SYNC : SEND;
                end
            end
            SYNC: begin
                if (!bus.tx_full) begin
                    w_wr_nxt       = 1'b1;
                    w_data_out_nxt = SYNC_BYTE;
                    w_state_nxt    = SEND;
                end
            end
            SEND: begin
                if (!bus.tx_full) begin
                    w_wr_nxt       = 1'b1;
                    w_data_out_nxt = w_sel;
                    w_cnt_nxt      = r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(NBYTES - 1)) begin
                        w_state_nxt = FIN;
                    end
                end
            end
            FIN: begin
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.data_out   = r_data_out;
    assign bus.wr         = r_wr;
    assign bus.rd         = 1'b0;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_done;

endmodule

// File: doc/uart_word_serializer.md
Name: uart_word_serializer

Overview:
- Parametrised successor to the board-test UART byte feeder.
- On a start request, captures a DATA_W-bit result word (e.g. register/memory dump from the single-cycle MIPS core).
- Emits the word as a byte stream into the UART TX FIFO write port, with optional sync byte, selectable byte order and FIFO-full backpressure.
- Sits between the core's result/done logic and the UART TX core on the board-test top level.

Parameters:
- DATA_W, 64, word width in bits; must be a multiple of 8, range 8..256.
- LSB_FIRST, 1, 1 = byte 0 (bits 7:0) sent first; 0 = most-significant byte first.
- SYNC_EN, 0, 1 = prepend SYNC_BYTE to every frame.
- SYNC_BYTE, 8'hA5, preamble value sent when SYNC_EN = 1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  frame request; only the rising edge is acted on.
- data_in  input  DATA_W  word to send; sampled only on the accepted start edge.
- tx_full  input  1  UART TX FIFO full; no write may be issued while it is high.
- data_out  output  8  byte presented to the FIFO; valid only when wr = 1.
- wr  output  1  one-cycle FIFO write strobe per byte.
- rd  output  1  FIFO read strobe; constant 0 (kept for UART core port compatibility).
- busy  output  1  high from capture until the last byte is written.
- frame_done  output  1  one-cycle pulse in the cycle after the last byte's wr.

Behaviour:
- Derived constant: NBYTES = DATA_W/8. Frame length is NBYTES + SYNC_EN.
- Byte counter width is clog2(NBYTES+2) and must not wrap within a frame.
- All outputs are registered. Reset values: data_out = 0, wr = 0, rd = 0, busy = 0, frame_done = 0. Internal state: IDLE, shadow word = 0, counter = 0, start_d = 0.
- Start edge detect: start_d registers start; a rising edge is start & ~start_d.
  - Holding start high yields exactly one frame.
  - A new frame requires start to go low, then high again.
- State IDLE:
  - On rising edge at posedge N: capture data_in into the shadow register, clear counter, busy = 1.
  - Go to SYNC if SYNC_EN, else to SEND.
- State SYNC:
  - At a posedge with tx_full = 0: wr = 1, data_out = SYNC_BYTE, go to SEND.
  - With tx_full = 1: wr = 0, stay in SYNC.
- State SEND:
  - At each posedge with tx_full = 0: wr = 1, data_out = selected byte, counter += 1.
  - Selected byte index is counter if LSB_FIRST = 1, else NBYTES-1-counter.
  - With tx_full = 1: wr = 0, data_out holds its value, counter holds.
  - When the byte with counter = NBYTES-1 is written, go to FIN.
- State FIN (one cycle): wr = 0, busy = 0, frame_done = 1, return to IDLE.
- Latency with SYNC_EN = 0 and no backpressure:
  - Start edge sampled at posedge N.
  - First wr is registered at posedge N+1.
  - Bytes follow on consecutive cycles; last wr at N+NBYTES.
  - frame_done at N+NBYTES+1.
- tx_full is sampled at the same posedge that would register wr; the write it gates is the one issued that cycle.
- Start edges while busy (SYNC/SEND/FIN) are ignored and not queued. start_d keeps tracking, so a level still high at the end of a frame does not retrigger.
- data_in changes after capture have no effect on the frame in flight.
- wr is never high for two bytes of the same index. Exactly NBYTES + SYNC_EN wr pulses occur per frame.
- Reset mid-frame:
  - At the next posedge: return to IDLE, wr = 0, busy = 0, no frame_done.
  - Partial output is abandoned. start_d is cleared, so a start still high after reset counts as a new edge.
- Simultaneous rst and start: rst wins; no capture.

Decomposition:
- Shared package uart_pkg holds:
  - state enum (IDLE, SYNC, SEND, FIN);
  - default SYNC_BYTE constant;
  - function for the byte-index calculation from counter, NBYTES and LSB_FIRST.
- One natural sub-module: rise_detect (start_d register plus edge output, synchronous reset). Everything else stays in one module.

Test Plan:
- DATA_W = 64, LSB_FIRST = 1, SYNC_EN = 0, tx_full = 0, data_in = 64'h0807060504030201, start pulse -> 8 consecutive wr with data_out 01,02,...,08; frame_done one cycle after the last wr; busy low afterwards.
- Same word with LSB_FIRST = 0, SYNC_EN = 1, SYNC_BYTE = A5 -> 9 wr pulses: A5,08,07,...,01.
- tx_full high for 3 cycles after the 2nd byte -> no wr during those 3 cycles; remaining bytes 03..08 resume with no byte skipped or duplicated; total 8 wr pulses.
- start held high for 40 cycles, plus a second start edge during byte 4 -> exactly one frame of 8 wr pulses; no second frame until start goes low then high.
- rst asserted in the cycle after the 5th wr -> wr = 0 and busy = 0 at the next posedge, no frame_done. A fresh start then sends all 8 bytes starting from 01.
- DATA_W = 8, SYNC_EN = 0, data_in = 8'h3C -> single wr with 3C, frame_done one cycle later.
